// File: rtl/vdu_console_wr.sv
// Console writer: turns a byte stream into Wishbone text-buffer writes for the vdu,
// keeping a cursor, honouring CR/LF/BS/FF and blanking rows as the cursor enters them.
module vdu_console_wr #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 25,
  parameter logic [7:0] ATTR           = 8'h07,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  chr_i,
  input  logic        chr_valid_i,
  output logic        chr_ready_o,
  output logic [15:0] wb_dat_o,
  output logic [10:0] wb_adr_o,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic [6:0]  col_o,
  output logic [4:0]  row_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_CLRSCR,
    ST_IDLE,
    ST_PUT,
    ST_CLRROW
  } state_t;

  localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COLS_W    = 11'(COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [15:0] BLANK     = {ATTR, 8'h20};

  state_t      state;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [10:0] clr_addr;
  logic        stb;
  logic        we;
  logic [1:0]  sel;
  logic [10:0] adr;
  logic [15:0] dat;
  logic        ready;
  logic        busy;

  logic [4:0]  next_row;
  logic [10:0] row_base;
  logic [10:0] next_row_base;
  logic [10:0] clr_last;

  // Rows wrap instead of scrolling, so the row below the last is row 0.
  assign next_row      = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign row_base      = 11'(row) * COLS_W;
  assign next_row_base = 11'(next_row) * COLS_W;
  assign clr_last      = (state == ST_CLRSCR) ? LAST_ADDR : row_base + COLS_W - 11'd1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= CLEAR_ON_RESET ? ST_CLRSCR : ST_IDLE;
      col      <= 7'd0;
      row      <= 5'd0;
      clr_addr <= 11'd0;
      stb      <= 1'b0;
      we       <= 1'b0;
      sel      <= 2'b00;
      adr      <= 11'd0;
      dat      <= 16'd0;
      ready    <= 1'b0;
      busy     <= CLEAR_ON_RESET;
    end else begin
      case (state)
        // Both clears share one walker; stb idles one cycle between writes.
        ST_CLRSCR, ST_CLRROW: begin
          if (!stb) begin
            stb <= 1'b1;
            we  <= 1'b1;
            sel <= 2'b11;
            adr <= clr_addr;
            dat <= BLANK;
          end else if (wb_ack_i) begin
            stb <= 1'b0;
            we  <= 1'b0;
            sel <= 2'b00;
            if (clr_addr == clr_last) begin
              if (state == ST_CLRSCR) begin
                col <= 7'd0;
                row <= 5'd0;
              end
              state <= ST_IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              clr_addr <= clr_addr + 11'd1;
            end
          end
        end

        ST_IDLE: begin
          if (chr_valid_i && ready) begin
            if (chr_i >= 8'h20) begin
              stb   <= 1'b1;
              we    <= 1'b1;
              sel   <= 2'b11;
              adr   <= row_base + 11'(col);
              dat   <= {ATTR, chr_i};
              ready <= 1'b0;
              state <= ST_PUT;
            end else begin
              case (chr_i)
                8'h0D: col <= 7'd0;
                8'h0A: begin
                  row      <= next_row;
                  clr_addr <= next_row_base;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_CLRROW;
                end
                8'h08: begin
                  if (col != 7'd0) col <= col - 7'd1;
                end
                8'h0C: begin
                  clr_addr <= 11'd0;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_CLRSCR;
                end
                default: ;
              endcase
            end
          end else begin
            ready <= 1'b1;
          end
        end

        // Wrapping past the last column acts as an implicit newline.
        ST_PUT: begin
          if (stb && wb_ack_i) begin
            stb <= 1'b0;
            we  <= 1'b0;
            sel <= 2'b00;
            if (col == LAST_COL) begin
              col      <= 7'd0;
              row      <= next_row;
              clr_addr <= next_row_base;
              busy     <= 1'b1;
              state    <= ST_CLRROW;
            end else begin
              col   <= col + 7'd1;
              ready <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign chr_ready_o = ready;
  assign wb_dat_o    = dat;
  assign wb_adr_o    = adr;
  assign wb_we_o     = we;
  assign wb_tga_o    = 1'b0;
  assign wb_sel_o    = sel;
  assign wb_stb_o    = stb;
  assign wb_cyc_o    = stb;
  assign col_o       = col;
  assign row_o       = row;
  assign busy_o      = busy;

endmodule

// File: tb/tb_vdu_console_wr.sv
// Self-checking bench for vdu_console_wr: a cursor/screen model predicts every
// bus write, and a Wishbone slave with adjustable ack latency records them.
module tb_vdu_console_wr;

  localparam int         COLS = 80;
  localparam int         ROWS = 25;
  localparam logic [7:0] ATTR = 8'h07;
  localparam int         WAIT_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  chr_i = 8'h00;
  logic        chr_valid_i = 1'b0;
  logic        chr_ready_o;
  logic [15:0] wb_dat_o;
  logic [10:0] wb_adr_o;
  logic        wb_we_o;
  logic        wb_tga_o;
  logic [1:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic [6:0]  col_o;
  logic [4:0]  row_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vdu_console_wr #(
    .COLS(COLS), .ROWS(ROWS), .ATTR(ATTR), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .chr_i(chr_i), .chr_valid_i(chr_valid_i), .chr_ready_o(chr_ready_o),
    .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .col_o(col_o), .row_o(row_o), .busy_o(busy_o)
  );

  // Slave: acks after ack_delay wait cycles; outside a cycle ack may be tied or noisy.
  int ack_delay = 0;
  bit ack_tied = 1'b1;
  bit noise_en = 1'b0;
  bit noise_bit = 1'b0;
  int wcnt;

  assign wb_ack_i = wb_stb_o ? (wcnt >= ack_delay) : (ack_tied | (noise_en & noise_bit));

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (wb_stb_o) wcnt <= wb_ack_i ? 0 : wcnt + 1;
  end

  always @(negedge clk) noise_bit = 1'($urandom_range(0, 1));

  // Write log plus protocol watch: held signals, no back-to-back strobes, fixed sel/we/tga.
  logic [26:0] act_q[$];
  logic [26:0] exp_q[$];
  int          prot_err = 0;
  bit          prev_pend = 1'b0;
  bit          prev_acked = 1'b0;
  logic [10:0] prev_adr;
  logic [15:0] prev_dat;

  always @(posedge clk) begin
    if (rst) begin
      prev_pend  = 1'b0;
      prev_acked = 1'b0;
    end else begin
      if (prev_acked && wb_stb_o) prot_err++;
      if (prev_pend && (!wb_stb_o || wb_adr_o !== prev_adr || wb_dat_o !== prev_dat)) prot_err++;
      if (wb_stb_o && (wb_we_o !== 1'b1 || wb_sel_o !== 2'b11 || wb_tga_o !== 1'b0)) prot_err++;
      if (wb_cyc_o !== wb_stb_o) prot_err++;
      if (wb_stb_o && wb_ack_i) act_q.push_back({wb_adr_o, wb_dat_o});
      prev_acked = wb_stb_o && wb_ack_i;
      prev_pend  = wb_stb_o && !wb_ack_i;
      prev_adr   = wb_adr_o;
      prev_dat   = wb_dat_o;
    end
  end

  // Reference model: a screen cursor and the list of cells it should write.
  int m_col = 0;
  int m_row = 0;

  function automatic void m_blank(input int a);
    exp_q.push_back({11'(a), ATTR, 8'h20});
  endfunction

  function automatic void m_newline();
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) m_blank(m_row * COLS + i);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < COLS * ROWS; i++) m_blank(i);
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b >= 8'h20) begin
      exp_q.push_back({11'(m_row * COLS + m_col), ATTR, b});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_newline();
      end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) m_newline();
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) m_clear();
  endfunction

  function automatic int first_diff();
    int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (act_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!chr_ready_o && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!chr_ready_o) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout ready=%b required 1", chr_ready_o);
    end else begin
      chr_i = b;
      chr_valid_i = 1'b1;
      m_byte(b);
      @(posedge clk);
      #1 chr_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < WAIT_LIMIT) begin
      @(negedge clk);
      ok = chr_ready_o && !wb_stb_o;
      n++;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d;
    rst = 1'b0;
    ack_tied = 1'b1;
    ack_delay = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stb stb=%b cyc=%b required 0", wb_stb_o, wb_cyc_o); end
    checks++; if (wb_we_o !== 1'b0 || wb_sel_o !== 2'b00) begin errors++; $display("[TB] FAIL rst_we_sel we=%b sel=%b required 0/00", wb_we_o, wb_sel_o); end
    checks++; if (wb_adr_o !== 11'd0 || wb_dat_o !== 16'd0) begin errors++; $display("[TB] FAIL rst_adr_dat adr=%h dat=%h required 0", wb_adr_o, wb_dat_o); end
    checks++; if (col_o !== 7'd0 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL rst_cursor col=%0d row=%0d required 0,0", col_o, row_o); end
    checks++; if (chr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b required 0", chr_ready_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy got %b required 1", busy_o); end
    act_q.delete();
    m_clear();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 11'd0) begin errors++; $display("[TB] FAIL first_strobe stb=%b adr=%0d required 1/0", wb_stb_o, wb_adr_o); end
    checks++; if (busy_o !== 1'b1 || chr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy busy=%b ready=%b required 1/0", busy_o, chr_ready_o); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clrscr_timeout idle=%b required 1", ok); end
    checks++; if (act_q.size() !== 2000) begin errors++; $display("[TB] FAIL clrscr_count got %0d required 2000", act_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("[TB] FAIL clrscr_data[%0d] got %h required %h", d, act_q[d], exp_q[d]); end
    checks++; if (busy_o !== 1'b0 || col_o !== 7'd0 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL clrscr_end busy=%b col=%0d row=%0d required 0,0,0", busy_o, col_o, row_o); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_put_char();
    bit ok;
    ack_tied = 1'b0;
    send_byte(8'h41);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL put_timeout idle=%b required 1", ok); end
    checks++; if (act_q.size() !== 1) begin errors++; $display("[TB] FAIL put_count got %0d required 1", act_q.size()); end
    else begin
      checks++; if (act_q[0] !== {11'd0, 16'h0741}) begin errors++; $display("[TB] FAIL put_write got %h required %h", act_q[0], {11'd0, 16'h0741}); end
    end
    checks++; if (col_o !== 7'd1 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL put_cursor col=%0d row=%0d required 1,0", col_o, row_o); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_line_wrap();
    bit ok;
    int d;
    send_byte(8'h0D);
    for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(32, 255)));
    send_byte(8'h42);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_timeout idle=%b required 1", ok); end
    checks++; if (act_q.size() !== 161) begin errors++; $display("[TB] FAIL wrap_count got %0d required 161", act_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("[TB] FAIL wrap_data[%0d] got %h required %h", d, act_q[d], exp_q[d]); end
    checks++; if (act_q.size() > 0 && act_q[act_q.size()-1] !== {11'd80, 16'h0742}) begin errors++; $display("[TB] FAIL wrap_B got %h required %h", act_q[act_q.size()-1], {11'd80, 16'h0742}); end
    checks++; if (col_o !== 7'd1 || row_o !== 5'd1) begin errors++; $display("[TB] FAIL wrap_cursor col=%0d row=%0d required 1,1", col_o, row_o); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_row_wrap_controls();
    bit ok;
    int d;
    while (m_row != ROWS - 1) send_byte(8'h0A);
    send_byte(8'h0D);
    for (int i = 0; i < 5; i++) send_byte(8'h2E);
    wait_idle(ok);
    act_q.delete(); exp_q.delete();
    checks++; if (col_o !== 7'd5 || row_o !== 5'd24) begin errors++; $display("[TB] FAIL pre_lf_cursor col=%0d row=%0d required 5,24", col_o, row_o); end
    send_byte(8'h0A);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL lf_timeout idle=%b required 1", ok); end
    checks++; if (act_q.size() !== 80) begin errors++; $display("[TB] FAIL lf_count got %0d required 80", act_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("[TB] FAIL lf_data[%0d] got %h required %h", d, act_q[d], exp_q[d]); end
    checks++; if (col_o !== 7'd5 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL lf_cursor col=%0d row=%0d required 5,0", col_o, row_o); end
    act_q.delete(); exp_q.delete();
    send_byte(8'h0D); send_byte(8'h08); send_byte(8'h08);
    wait_idle(ok);
    checks++; if (act_q.size() !== 0) begin errors++; $display("[TB] FAIL ctrl_writes got %0d required 0", act_q.size()); end
    checks++; if (col_o !== 7'd0 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL ctrl_cursor col=%0d row=%0d required 0,0", col_o, row_o); end
    send_byte(8'h78); send_byte(8'h79); send_byte(8'h08); send_byte(8'h1B);
    wait_idle(ok);
    checks++; if (col_o !== 7'd1 || row_o !== 5'd0) begin errors++; $display("[TB] FAIL bs_cursor col=%0d row=%0d required 1,0", col_o, row_o); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_ack_delay();
    bit ok;
    logic [10:0] e_adr;
    e_adr = 11'(m_row * COLS + m_col);
    ack_delay = 3;
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (wb_stb_o !== 1'b1 || chr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_stb[%0d] stb=%b ready=%b required 1/0", i, wb_stb_o, chr_ready_o); end
      checks++; if (wb_adr_o !== e_adr || wb_dat_o !== 16'h075A) begin errors++; $display("[TB] FAIL hold_bus[%0d] adr=%0d dat=%h required %0d/075a", i, wb_adr_o, wb_dat_o, e_adr); end
    end
    @(negedge clk);
    checks++; if (wb_stb_o !== 1'b0 || chr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_release stb=%b ready=%b required 0/1", wb_stb_o, chr_ready_o); end
    wait_idle(ok);
    checks++; if (act_q.size() !== 1 || exp_q.size() !== 1) begin errors++; $display("[TB] FAIL hold_count got %0d required 1", act_q.size()); end
    act_q.delete(); exp_q.delete();
    ack_delay = 0;
  endtask

  task automatic test_random_stream();
    bit ok;
    int d;
    int r;
    int ff_left = 1;
    logic [7:0] b;
    ack_delay = $urandom_range(0, 2);
    noise_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) b = 8'h0A;
      else if (r < 14) b = 8'h0D;
      else if (r < 20) b = 8'h08;
      else if (r < 25) b = 8'($urandom_range(0, 31));
      else if (r < 26) b = 8'h0C;
      else b = 8'($urandom_range(32, 255));
      if (b == 8'h0C) begin
        if (ff_left == 0) b = 8'h07;
        else ff_left--;
      end
      send_byte(b);
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_timeout idle=%b required 1", ok); end
    checks++; if (act_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_count got %0d required %0d", act_q.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("[TB] FAIL rand_data[%0d] got %h required %h", d, act_q[d], exp_q[d]); end
    checks++; if (col_o !== 7'(m_col) || row_o !== 5'(m_row)) begin errors++; $display("[TB] FAIL rand_cursor col=%0d row=%0d required %0d,%0d", col_o, row_o, m_col, m_row); end
    act_q.delete(); exp_q.delete();
    noise_en = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_cycle();
    bit ok;
    int d;
    ack_delay = 3;
    send_byte(8'h51);
    @(negedge clk);
    checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_stb got %b required 1", wb_stb_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_async stb=%b cyc=%b required 0", wb_stb_o, wb_cyc_o); end
    checks++; if (col_o !== 7'd0 || busy_o !== 1'b1 || chr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_state col=%0d busy=%b ready=%b required 0/1/0", col_o, busy_o, chr_ready_o); end
    act_q.delete(); exp_q.delete();
    m_clear();
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 11'd0) begin errors++; $display("[TB] FAIL mid_restart stb=%b adr=%0d required 1/0", wb_stb_o, wb_adr_o); end
    wait_idle(ok);
    checks++; if (act_q.size() !== 2000) begin errors++; $display("[TB] FAIL mid_count got %0d required 2000", act_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("[TB] FAIL mid_data[%0d] got %h required %h", d, act_q[d], exp_q[d]); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_protocol();
    checks++; if (prot_err !== 0) begin errors++; $display("[TB] FAIL protocol violations=%0d required 0", prot_err); end
  endtask

  initial begin
    test_reset();
    test_put_char();
    test_line_wrap();
    test_row_wrap_controls();
    test_ack_delay();
    test_random_stream();
    test_reset_mid_cycle();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog time=%0t limit=900000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
